// File: rtl/codix_risc_mem_arbiter.sv
// rtl/codix_risc_mem_arbiter.sv - two-port (fetch/data) arbiter onto a single-port synchronous memory
// Alternating priority on contention; misaligned accesses are answered with an error, never reach memory.
module codix_risc_mem_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             halt,
    input  logic             i_req,
    input  logic [AW-1:0]    i_addr,
    output logic             i_ack,
    output logic             i_err,
    output logic [DW-1:0]    i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [AW-1:0]    d_addr,
    input  logic [DW-1:0]    d_wdata,
    output logic             d_ack,
    output logic             d_err,
    output logic [DW-1:0]    d_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] i_cnt,
    output logic [CNT_W-1:0] d_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;

    state_t         state;
    logic           owner_d;
    logic           we_r;
    logic           last_d;

    logic           i_elig;
    logic           d_elig;
    logic           grant;
    logic           pick_d;
    logic [AW-1:0]  g_addr;
    logic [DW-1:0]  g_wdata;
    logic           g_we;
    logic           g_ok;

    // The port being acknowledged this cycle may not win again in the same cycle.
    always_comb begin
        i_elig  = i_req && !(state == RESP && !owner_d);
        d_elig  = d_req && !(state == RESP && owner_d);
        grant   = (state != ISSUE) && (state != ERR) && !halt && (i_elig || d_elig);
        pick_d  = d_elig && (!i_elig || !last_d);
        g_addr  = pick_d ? d_addr : i_addr;
        g_wdata = pick_d ? d_wdata : '0;
        g_we    = pick_d && d_we;
        g_ok    = (g_addr[1:0] == 2'b00);
    end

    assign busy    = (state != IDLE);
    assign i_rdata = (i_ack && !i_err) ? mem_rdata : '0;
    assign d_rdata = (d_ack && !d_err && !we_r) ? mem_rdata : '0;

    // ERR mirrors the memory slot of ISSUE so error responses keep the same two-cycle latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            we_r      <= 1'b0;
            last_d    <= 1'b1;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_cnt     <= '0;
            d_cnt     <= '0;
        end else begin
            i_ack  <= 1'b0;
            i_err  <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                ISSUE: begin
                    state <= RESP;
                    if (owner_d) d_ack <= 1'b1;
                    else         i_ack <= 1'b1;
                end
                ERR: begin
                    state <= RESP;
                    if (owner_d) begin
                        d_ack <= 1'b1;
                        d_err <= 1'b1;
                    end else begin
                        i_ack <= 1'b1;
                        i_err <= 1'b1;
                    end
                end
                default: begin
                    if (grant) begin
                        last_d  <= pick_d;
                        owner_d <= pick_d;
                        we_r    <= g_we;
                        if (g_ok) begin
                            state     <= ISSUE;
                            mem_en    <= 1'b1;
                            mem_we    <= g_we;
                            mem_addr  <= g_addr;
                            mem_wdata <= g_wdata;
                            if (pick_d) begin
                                if (d_cnt != {CNT_W{1'b1}}) d_cnt <= d_cnt + CNT_W'(1);
                            end else begin
                                if (i_cnt != {CNT_W{1'b1}}) i_cnt <= i_cnt + CNT_W'(1);
                            end
                        end else begin
                            state <= ERR;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
